taus_seed_loader: RTL and testbench

- Front-end controller that drives the seed interface of the tausworthe uniform RNG and consumes its output stream.
- Accepts three 32-bit seed words over a valid/ready bus and validates them against taus88 minimum-state rules.
- Applies the seeds and pulses the generator reset, discards a warm-up run of samples, then forwards samples with a valid flag to the AWGN datapath (Box-Muller stage).

---
 rtl/taus_seed_loader.sv | 131 +++++++++++++
 tb/tb_taus_seed_loader.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/taus_seed_loader.sv
// Seed front-end for the taus88 uniform generator: collects and validates three seed
// words, resets the generator, discards a warm-up run, then streams samples downstream.
module taus_seed_loader #(
    parameter int RST_CYCLES = 2,
    parameter int WARMUP     = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] seed_data,
    input  logic        seed_valid,
    output logic        seed_ready,
    output logic        seed_err,
    output logic        taus_reset,
    output logic [31:0] s0,
    output logic [31:0] s1,
    output logic [31:0] s2,
    input  logic [31:0] r_in,
    output logic [31:0] rnd_out,
    output logic        rnd_valid,
    output logic        busy
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_CHECK = 3'd2;
    localparam logic [2:0] ST_RST   = 3'd3;
    localparam logic [2:0] ST_WARM  = 3'd4;
    localparam logic [2:0] ST_RUN   = 3'd5;

    logic [2:0]  state_reg;
    logic [1:0]  idx_reg;
    logic [7:0]  cnt_reg;
    logic [31:0] shadow_reg [3];
    logic [2:0]  below_min;
    logic        xfer;

    assign seed_ready = (state_reg == ST_IDLE) || (state_reg == ST_LOAD) || (state_reg == ST_RUN);
    assign busy       = (state_reg == ST_CHECK) || (state_reg == ST_RST) || (state_reg == ST_WARM);
    assign xfer       = seed_valid && seed_ready;

    // taus88 minimum-state rules, unsigned: s0 >= 2, s1 >= 8, s2 >= 16
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_min
            localparam logic [31:0] MIN_VAL = (gi == 0) ? 32'd2 : ((gi == 1) ? 32'd8 : 32'd16);
            assign below_min[gi] = shadow_reg[gi] < MIN_VAL;
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= ST_IDLE;
            idx_reg    <= 2'd0;
            cnt_reg    <= 8'd0;
            for (int i = 0; i < 3; i++) shadow_reg[i] <= 32'd0;
            s0         <= 32'd0;
            s1         <= 32'd0;
            s2         <= 32'd0;
            taus_reset <= 1'b1;
            seed_err   <= 1'b0;
            rnd_out    <= 32'd0;
            rnd_valid  <= 1'b0;
        end else begin
            seed_err <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (xfer) begin
                        shadow_reg[0] <= seed_data;
                        idx_reg       <= 2'd1;
                        state_reg     <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (xfer) begin
                        shadow_reg[idx_reg] <= seed_data;
                        if (idx_reg == 2'd2) begin
                            idx_reg   <= 2'd0;
                            state_reg <= ST_CHECK;
                        end else begin
                            idx_reg <= idx_reg + 2'd1;
                        end
                    end
                end
                ST_CHECK: begin
                    // A rejected set leaves the running seeds and generator reset untouched
                    if (|below_min) begin
                        seed_err  <= 1'b1;
                        state_reg <= ST_IDLE;
                    end else begin
                        s0         <= shadow_reg[0];
                        s1         <= shadow_reg[1];
                        s2         <= shadow_reg[2];
                        taus_reset <= 1'b1;
                        cnt_reg    <= 8'(RST_CYCLES);
                        state_reg  <= ST_RST;
                    end
                end
                ST_RST: begin
                    if (cnt_reg <= 8'd1) begin
                        taus_reset <= 1'b0;
                        cnt_reg    <= 8'(WARMUP);
                        state_reg  <= (WARMUP == 0) ? ST_RUN : ST_WARM;
                    end else begin
                        cnt_reg <= cnt_reg - 8'd1;
                    end
                end
                ST_WARM: begin
                    if (cnt_reg <= 8'd1) begin
                        state_reg <= ST_RUN;
                    end else begin
                        cnt_reg <= cnt_reg - 8'd1;
                    end
                end
                ST_RUN: begin
                    // A reseed freezes the output stream; the generator keeps its old seeds for now
                    if (xfer) begin
                        shadow_reg[0] <= seed_data;
                        idx_reg       <= 2'd1;
                        rnd_valid     <= 1'b0;
                        state_reg     <= ST_LOAD;
                    end else begin
                        rnd_out   <= r_in;
                        rnd_valid <= 1'b1;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_taus_seed_loader.sv
// Bench for taus_seed_loader: seed-set vectors, random sets against a rule/timeline
// model, mid-load reset, and a second build with no warm-up and a 1-cycle reset.
module tb_taus_seed_loader;

    localparam int RST_CYCLES = 2;
    localparam int WARMUP     = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] seed_data;
    logic        seed_valid;
    logic [31:0] r_in;

    logic        seed_ready, seed_err, taus_reset, rnd_valid, busy;
    logic [31:0] s0, s1, s2, rnd_out;
    logic        seed_ready2, seed_err2, taus_reset2, rnd_valid2, busy2;
    logic [31:0] s0_2, s1_2, s2_2, rnd_out2;

    int total = 0;
    int bad   = 0;

    logic [31:0] m_s [3];
    logic        m_taus;
    bit          m_running;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        bit          err;
        bit          toggle;
    } vec_t;

    vec_t tbl [8];

    taus_seed_loader #(.RST_CYCLES(RST_CYCLES), .WARMUP(WARMUP)) dut (
        .clk(clk), .reset(reset), .seed_data(seed_data), .seed_valid(seed_valid),
        .seed_ready(seed_ready), .seed_err(seed_err), .taus_reset(taus_reset),
        .s0(s0), .s1(s1), .s2(s2), .r_in(r_in), .rnd_out(rnd_out),
        .rnd_valid(rnd_valid), .busy(busy)
    );

    taus_seed_loader #(.RST_CYCLES(1), .WARMUP(0)) dut2 (
        .clk(clk), .reset(reset), .seed_data(seed_data), .seed_valid(seed_valid),
        .seed_ready(seed_ready2), .seed_err(seed_err2), .taus_reset(taus_reset2),
        .s0(s0_2), .s1(s1_2), .s2(s2_2), .r_in(r_in), .rnd_out(rnd_out2),
        .rnd_valid(rnd_valid2), .busy(busy2)
    );

    always #5 clk = ~clk;

    // Stand-in for the generator: a fresh sample every cycle, changed away from the edge
    initial begin
        r_in = 32'd0;
        forever begin
            @(negedge clk);
            r_in = $urandom;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [31:0] w);
        int n = 0;
        seed_data  = w;
        seed_valid = 1'b1;
        while (seed_ready !== 1'b1 && n < 100) begin
            step();
            n++;
        end
        chk("ready_wait", 32'(n < 100), 32'd1);
        step();
        seed_valid = 1'b0;
    endtask

    task automatic run_set(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                           input bit exp_err, input bit toggle);
        logic [31:0] w [3];
        logic [31:0] held;
        bit          was_running;
        int          n;
        w           = '{a, b, c};
        held        = rnd_out;
        was_running = m_running;
        for (int i = 0; i < 3; i++) begin
            send_word(w[i]);
            if (was_running) begin
                chk("reseed_valid_low", 32'(rnd_valid), 32'd0);
                chk("reseed_out_held", rnd_out, held);
            end
            if (toggle && i < 2) step();
        end
        chk("check_busy", 32'(busy), 32'd1);
        chk("check_ready", 32'(seed_ready), 32'd0);
        if (toggle) begin
            seed_data  = 32'hDEADBEEF;
            seed_valid = 1'b1;
        end
        step();
        if (exp_err) begin
            seed_valid = 1'b0;
            chk("err_pulse", 32'(seed_err), 32'd1);
            chk("err_s0", s0, m_s[0]);
            chk("err_s1", s1, m_s[1]);
            chk("err_s2", s2, m_s[2]);
            chk("err_taus", 32'(taus_reset), 32'(m_taus));
            chk("err_idle", 32'({busy, seed_ready}), 32'b01);
            chk("err_valid", 32'(rnd_valid), 32'd0);
            for (int k = 0; k < 3; k++) begin
                step();
                chk("err_single", 32'(seed_err), 32'd0);
                chk("err_no_stream", 32'(rnd_valid), 32'd0);
            end
            m_running = 1'b0;
        end else begin
            chk("ok_noerr", 32'(seed_err), 32'd0);
            chk("ok_s0", s0, a);
            chk("ok_s1", s1, b);
            chk("ok_s2", s2, c);
            n = 0;
            while (taus_reset === 1'b1 && n < 20) begin
                chk("rst_ready_low", 32'(seed_ready), 32'd0);
                n++;
                step();
            end
            seed_valid = 1'b0;
            chk("rst_len", n, RST_CYCLES);
            n = 0;
            while (rnd_valid !== 1'b1 && n < 300) begin
                if (n < WARMUP) chk("warm_ready_low", 32'(seed_ready), 32'd0);
                n++;
                step();
            end
            chk("warm_len", n, WARMUP + 1);
            chk("run_taus_low", 32'(taus_reset), 32'd0);
            for (int k = 0; k < 4; k++) begin
                chk("run_valid", 32'(rnd_valid), 32'd1);
                chk("run_sample", rnd_out, r_in);
                step();
            end
            m_s       = w;
            m_taus    = 1'b0;
            m_running = 1'b1;
        end
        $display("set %h %h %h toggle=%0d err=%0d", a, b, c, toggle, exp_err);
    endtask

    function automatic logic [31:0] rand_word();
        if ($urandom_range(0, 2) == 0) return 32'($urandom_range(0, 20));
        return $urandom;
    endfunction

    initial begin
        logic [31:0] ra, rb, rc;
        tbl[0] = '{32'h00000001, 32'h129f8963, 32'hffff3434, 1'b1, 1'b0};
        tbl[1] = '{32'h003110DA, 32'h129f8963, 32'hffff3434, 1'b0, 1'b0};
        tbl[2] = '{32'hCAFEBABE, 32'h12345678, 32'h87654321, 1'b0, 1'b1};
        tbl[3] = '{32'h00000010, 32'h00000100, 32'h00001000, 1'b0, 1'b0};
        tbl[4] = '{32'h00000002, 32'h00000007, 32'h00000010, 1'b1, 1'b0};
        tbl[5] = '{32'h00000002, 32'h00000008, 32'h00000010, 1'b0, 1'b1};
        tbl[6] = '{32'h00000002, 32'h00000008, 32'h0000000F, 1'b1, 1'b0};
        tbl[7] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0};

        reset      = 1'b1;
        seed_valid = 1'b0;
        seed_data  = 32'd0;
        m_s        = '{32'd0, 32'd0, 32'd0};
        m_taus     = 1'b1;
        m_running  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 32'(seed_ready), 32'd1);
        chk("rst_taus", 32'(taus_reset), 32'd1);
        chk("rst_seeds", s0 | s1 | s2, 32'd0);
        chk("rst_flags", 32'({seed_err, rnd_valid, busy}), 32'd0);
        chk("rst_out", rnd_out, 32'd0);
        chk("rst_taus2", 32'(taus_reset2), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        step();
        chk("idle_taus", 32'(taus_reset), 32'd1);
        chk("idle_ready", 32'(seed_ready), 32'd1);

        for (int i = 0; i < 8; i++)
            run_set(tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].err, tbl[i].toggle);

        for (int i = 0; i < 6; i++) begin
            ra = rand_word();
            rb = rand_word();
            rc = rand_word();
            run_set(ra, rb, rc, (ra < 32'd2) || (rb < 32'd8) || (rc < 32'd16), 1'b0);
        end

        // Reset lands after two words of a set; the partial set must vanish
        send_word(32'h00000111);
        send_word(32'h00000222);
        reset = 1'b1;
        #2;
        chk("mid_rst_ready", 32'(seed_ready), 32'd1);
        chk("mid_rst_taus", 32'(taus_reset), 32'd1);
        chk("mid_rst_seeds", s0 | s1 | s2, 32'd0);
        chk("mid_rst_flags", 32'({seed_err, rnd_valid, busy}), 32'd0);
        chk("mid_rst_out", rnd_out, 32'd0);
        chk("mid_rst_dut2", 32'({taus_reset2, rnd_valid2}), 32'b10);
        @(negedge clk);
        reset = 1'b0;
        step();
        send_word(32'h00000A01);
        send_word(32'h00000B02);
        send_word(32'h00000C03);
        step();
        chk("fresh_s0", s0, 32'h00000A01);
        chk("fresh_s1", s1, 32'h00000B02);
        chk("fresh_s2", s2, 32'h00000C03);
        chk("nowarm_s0", s0_2, 32'h00000A01);
        chk("nowarm_taus_hi", 32'(taus_reset2), 32'd1);
        chk("nowarm_valid_lo", 32'(rnd_valid2), 32'd0);
        step();
        chk("nowarm_taus_lo", 32'(taus_reset2), 32'd0);
        chk("nowarm_valid_wait", 32'(rnd_valid2), 32'd0);
        step();
        chk("nowarm_valid", 32'(rnd_valid2), 32'd1);
        chk("nowarm_sample", rnd_out2, r_in);
        $display("set 00000a01 00000b02 00000c03 after mid-load reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
